// File: rtl/gw2a_ddr_rdalign.sv
// DDR read-data aligner: per-lane 4:1 deserialised sample selection with an
// automatic calibration sweep over eight shift candidates against a known pattern.
module gw2a_ddr_rdalign #(
    parameter int WIDTH   = 16,
    parameter int SETTLE  = 3,  // must be >= 1
    parameter int MATCHES = 4   // 1..15
) (
    input  logic                 PCLK,
    input  logic                 RESET,
    input  logic [4*WIDTH-1:0]   DI,
    input  logic                 CAL_REQ,
    input  logic [1:0]           CAL_PAT,
    output logic [WIDTH-1:0]     Q0,
    output logic [WIDTH-1:0]     Q1,
    output logic [3*WIDTH-1:0]   SHIFT_O,
    output logic                 CAL_BUSY,
    output logic                 CAL_DONE,
    output logic                 CAL_FAIL,
    output logic [WIDTH-1:0]     FAIL_MASK
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(MATCHES - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_NEXT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       k;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] locked;

    logic start, in_settle, in_check, check_end, finish, advance;

    always_comb begin
        start     = (state == ST_IDLE) && CAL_REQ;
        in_settle = (state == ST_SETTLE);
        in_check  = (state == ST_CHECK);
        check_end = in_check && (cnt == CHECK_LAST);
        finish    = (state == ST_NEXT) && ((&locked) || (k == 3'd7));
        advance   = (state == ST_NEXT) && !finish;
        CAL_BUSY  = in_settle || in_check || (state == ST_NEXT);
        CAL_DONE  = (state == ST_DONE);
        CAL_FAIL  = |FAIL_MASK;
    end

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            k     <= 3'd0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CAL_REQ) begin
                        state <= ST_SETTLE;
                        k     <= 3'd0;
                        cnt   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (cnt == CHECK_LAST) begin
                        cnt   <= '0;
                        state <= ST_NEXT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (finish) begin
                        state <= ST_DONE;
                    end else begin
                        k     <= k + 3'd1;
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [3:0] s;
        logic [2:0] shift_r;
        logic       q0_sel, q1_sel, q1_prev, q0_r, q1_r;
        logic       lock_r, ok_r, fail_r, match;

        assign s = DI[4*i +: 4];

        always_comb begin
            q0_sel = s[0];
            q1_sel = s[2];
            case (shift_r[1:0])
                2'd0: begin q0_sel = s[0]; q1_sel = s[2]; end
                2'd1: begin q0_sel = s[1]; q1_sel = s[3]; end
                2'd2: begin q0_sel = s[2]; q1_sel = s[0]; end
                2'd3: begin q0_sel = s[3]; q1_sel = s[1]; end
                default: begin q0_sel = s[0]; q1_sel = s[2]; end
            endcase
        end

        // shift[2] moves the pair boundary by one half-cycle using last cycle's q1
        always_ff @(posedge PCLK) begin
            if (RESET) begin
                q1_prev <= 1'b0;
                q0_r    <= 1'b0;
                q1_r    <= 1'b0;
            end else begin
                q1_prev <= q1_sel;
                if (shift_r[2]) begin
                    q0_r <= q1_prev;
                    q1_r <= q0_sel;
                end else begin
                    q0_r <= q0_sel;
                    q1_r <= q1_sel;
                end
            end
        end

        assign match = ({q1_r, q0_r} == CAL_PAT);

        always_ff @(posedge PCLK) begin
            if (RESET) begin
                shift_r <= 3'd0;
                lock_r  <= 1'b0;
                ok_r    <= 1'b0;
                fail_r  <= 1'b0;
            end else if (start) begin
                shift_r <= 3'd0;
                lock_r  <= 1'b0;
                fail_r  <= 1'b0;
            end else if (in_settle) begin
                ok_r <= 1'b1;
            end else if (in_check) begin
                ok_r <= ok_r && match;
                if (check_end && ok_r && match) begin
                    lock_r <= 1'b1;
                end
            end else if (finish && !lock_r) begin
                fail_r  <= 1'b1;
                shift_r <= 3'd0;
            end else if (advance && !lock_r) begin
                shift_r <= k + 3'd1;
            end
        end

        assign Q0[i]             = q0_r;
        assign Q1[i]             = q1_r;
        assign SHIFT_O[3*i +: 3] = shift_r;
        assign locked[i]         = lock_r;
        assign FAIL_MASK[i]      = fail_r;
    end

endmodule

// File: doc/gw2a_ddr_rdalign.md
GW2A_DDR_RDALIGN -- requirements
Module: gw2a_ddr_rdalign

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of DQ lanes.
REQ-002 SHALL have parameter SETTLE, default 3: idle PCLK cycles after each shift change before checking.
REQ-003 SHALL have parameter MATCHES, default 4: consecutive matching cycles needed to lock a lane (1..15).
REQ-004 SHALL have port PCLK, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port DI, input, 4*WIDTH: lane i deserialised samples DI[4i+3:4i] = {s3,s2,s1,s0}, s0 earliest.
REQ-007 SHALL have port CAL_REQ, input, 1: one-cycle calibration start request.
REQ-008 SHALL have port CAL_PAT, input, 2: expected aligned {Q1,Q0} value per lane during calibration.
REQ-009 SHALL have port Q0, output, WIDTH: aligned first-half sample per lane.
REQ-010 SHALL have port Q1, output, WIDTH: aligned second-half sample per lane.
REQ-011 SHALL have port SHIFT_O, output, 3*WIDTH: current shift per lane, lane i at [3i+2:3i].
REQ-012 SHALL have port CAL_BUSY, output, 1: high while calibration runs.
REQ-013 SHALL have port CAL_DONE, output, 1: one-cycle pulse at calibration end.
REQ-014 SHALL have port CAL_FAIL, output, 1: level, high if any lane failed last calibration.
REQ-015 SHALL have port FAIL_MASK, output, WIDTH: per-lane failure flags from last calibration.

Function
REQ-016 Per lane, SHALL select {q0,q1} from shift[1:0]: 00={s0,s2}, 01={s1,s3}, 10={s2,s0}, 11={s3,s1}.
REQ-017 Per lane, SHALL register q1 each cycle into q1_prev.
REQ-018 If shift[2]=0, SHALL output Q0=q0, Q1=q1; if shift[2]=1, SHALL output Q0=q1_prev, Q1=q0.
REQ-019 Q0/Q1 SHALL be registered: one PCLK latency from DI.
REQ-020 SHALL implement FSM states IDLE, SETTLE, CHECK, NEXT, DONE.
REQ-021 From IDLE, CAL_REQ=1 SHALL go to SETTLE with candidate k=0, clear all lock flags, FAIL_MASK, and CAL_FAIL.
REQ-022 CAL_REQ outside IDLE SHALL be ignored.
REQ-023 SETTLE SHALL last exactly SETTLE cycles, then enter CHECK.
REQ-024 CHECK SHALL last exactly MATCHES cycles, comparing each unlocked lane's registered {Q1,Q0} against CAL_PAT every cycle.
REQ-025 An unlocked lane matching on all MATCHES cycles SHALL lock with shift=k at CHECK exit; a single mismatch SHALL prevent locking at this k.
REQ-026 NEXT SHALL enter DONE if all lanes are locked or k=7; otherwise SHALL set k=k+1 and enter SETTLE.
REQ-027 While busy, an unlocked lane's SHIFT_O SHALL equal k; a locked lane's SHIFT_O SHALL stay at its lock value.
REQ-028 At DONE, each still-unlocked lane SHALL set its FAIL_MASK bit and take shift 0.
REQ-029 At DONE, CAL_FAIL SHALL be the OR of FAIL_MASK.
REQ-030 DONE SHALL pulse CAL_DONE for one cycle and return to IDLE.
REQ-031 CAL_BUSY SHALL be high in SETTLE, CHECK, and NEXT; low in IDLE and DONE.
REQ-032 Outside calibration, shifts SHALL hold their values; Q0/Q1 SHALL stay live in all states.
REQ-033 Maximum calibration length SHALL be 8*(SETTLE+MATCHES+1)+1 cycles.

Reset
REQ-034 RESET=1 SHALL force, at the next edge: FSM=IDLE; k, lock flags, and all shifts=0; Q0, Q1, q1_prev=0.
REQ-035 RESET=1 SHALL also force CAL_BUSY, CAL_DONE, CAL_FAIL, and FAIL_MASK=0.
REQ-036 RESET SHALL override CAL_REQ in the same cycle and SHALL abort any calibration in progress, with no CAL_DONE pulse.

Verification
REQ-037 Reset, then DI lane0 {s3..s0}=4'b0101 with shift 0 -> one cycle later Q0=1, Q1=1; all status outputs 0.
REQ-038 WIDTH=2, CAL_PAT=2'b01; lane0 DI=4'b0001 steady, lane1 DI=4'b0010 steady; CAL_REQ pulse -> SHIFT_O lane0=0, lane1=1, CAL_FAIL=0, CAL_DONE one pulse.
REQ-039 Lane DI toggling so that only shift=4 satisfies CAL_PAT=2'b01 -> lane locks at 4; Q0 equals the prior cycle's q1.
REQ-040 One lane with DI constantly 4'b1111 and CAL_PAT=2'b01 -> after exactly 8*(SETTLE+MATCHES+1)+1 cycles, FAIL_MASK bit=1, CAL_FAIL=1, that lane's shift=0.
REQ-041 Single mismatch injected on the 3rd CHECK cycle at the correct k -> lane does not lock there; it locks at a later k only if that k matches.
REQ-042 RESET asserted during CHECK, then CAL_REQ asserted while busy -> FSM returns to IDLE, no CAL_DONE, all shifts 0; a CAL_REQ while busy is ignored.
